// File: rtl/decode_pkg.sv
// Shared opcode, funct7 and immediate-type encodings for the RV32I/RV64I decode stage.
package decode_pkg;

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpImm32  = 7'b0011011;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpFence  = 7'b0001111;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [6:0] F7Base = 7'b0000000;
  localparam logic [6:0] F7Alt  = 7'b0100000;
  localparam logic [6:0] F7Mul  = 7'b0000001;

  typedef enum logic [2:0] {
    ImmNone  = 3'd0,
    ImmI     = 3'd1,
    ImmS     = 3'd2,
    ImmB     = 3'd3,
    ImmU     = 3'd4,
    ImmJ     = 3'd5,
    ImmShamt = 3'd6
  } imm_type_e;

  // opcode(7) + rs1/rs2/rd(15) + funct3(3) + funct7(7) + imm_type(3) + illegal(1) + imm + pc
  function automatic int unsigned entry_bits(int unsigned xlen, int unsigned pc_w);
    return 36 + xlen + pc_w;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Upstream instruction and downstream decoded-entry handshake bundle for decode_stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = 32
);
  logic            flush;
  logic            inValid;
  logic            inReady;
  logic [31:0]     instruction;
  logic [PC_W-1:0] pcIn;
  logic            outValid;
  logic            outReady;
  logic [6:0]      opCode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [2:0]      immType;
  logic            illegal;
  logic [PC_W-1:0] pcOut;

  modport master (
    output flush, inValid, instruction, pcIn, outReady,
    input  inReady, outValid, opCode, rs1, rs2, rd, funct3, funct7, imm, immType, illegal, pcOut
  );

  modport slave (
    input  flush, inValid, instruction, pcIn, outReady,
    output inReady, outValid, opCode, rs1, rs2, rd, funct3, funct7, imm, immType, illegal, pcOut
  );
endinterface

// File: rtl/decode_comb.sv
// Combinational RV32I/RV64I (+M) field extraction, immediate generation and legality check.
module decode_comb import decode_pkg::*; #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic [31:0]     instr_i,
  output logic [6:0]      opcode_o,
  output logic [4:0]      rs1_o,
  output logic [4:0]      rs2_o,
  output logic [4:0]      rd_o,
  output logic [2:0]      funct3_o,
  output logic [6:0]      funct7_o,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o
);
  localparam bit Rv64 = (XLEN == 64);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       use_rs1, use_rs2, use_rd, ill;
  logic       shift_zero, shift_sra, shift_ok, op_f7_ok;
  imm_type_e  itype;

  assign opc      = instr_i[6:0];
  assign f3       = instr_i[14:12];
  assign f7       = instr_i[31:25];
  assign opcode_o = opc;
  assign funct3_o = f3;
  assign funct7_o = f7;

  // RV64 shifts steal bit 25 for shamt, so only the top six bits qualify the shift kind.
  assign shift_zero = Rv64 ? (instr_i[31:26] == 6'b000000) : (f7 == F7Base);
  assign shift_sra  = Rv64 ? (instr_i[31:26] == 6'b010000) : (f7 == F7Alt);
  assign shift_ok   = shift_zero || (shift_sra && f3 == 3'b101);
  assign op_f7_ok   = (f7 == F7Base) || (f7 == F7Alt && (f3 == 3'b000 || f3 == 3'b101)) ||
                      (ENABLE_M && f7 == F7Mul);

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    itype   = ImmNone;
    ill     = (instr_i[1:0] != 2'b11);
    unique case (opc)
      OpLui, OpAuipc: begin
        itype  = ImmU;
        use_rd = 1'b1;
      end
      OpJal: begin
        itype  = ImmJ;
        use_rd = 1'b1;
      end
      OpJalr: begin
        itype   = ImmI;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OpLoad: begin
        itype   = ImmI;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        if (f3 == 3'b111 || (!Rv64 && (f3 == 3'b011 || f3 == 3'b110))) ill = 1'b1;
      end
      OpStore: begin
        itype   = ImmS;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (f3 > (Rv64 ? 3'd3 : 3'd2)) ill = 1'b1;
      end
      OpBranch: begin
        itype   = ImmB;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        if (f3[2:1] == 2'b01) ill = 1'b1;
      end
      OpImm, OpImm32: begin
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
        if (opc == OpImm32 && !Rv64) ill = 1'b1;
        if (f3[1:0] == 2'b01) begin
          itype = ImmShamt;
          if (!shift_ok) ill = 1'b1;
        end else begin
          itype = ImmI;
        end
      end
      OpOp, OpOp32: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
        if (opc == OpOp32 && !Rv64) ill = 1'b1;
        if (!op_f7_ok) ill = 1'b1;
      end
      OpFence, OpSystem: ;
      default: ill = 1'b1;
    endcase
  end

  always_comb begin
    rs1_o      = '0;
    rs2_o      = '0;
    rd_o       = '0;
    imm_o      = '0;
    imm_type_o = ImmNone;
    illegal_o  = ill;
    if (!ill) begin
      rs1_o      = use_rs1 ? instr_i[19:15] : 5'd0;
      rs2_o      = use_rs2 ? instr_i[24:20] : 5'd0;
      rd_o       = use_rd  ? instr_i[11:7]  : 5'd0;
      imm_type_o = itype;
      unique case (itype)
        ImmI:     imm_o = XLEN'($signed(instr_i[31:20]));
        ImmS:     imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        ImmB:     imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                         instr_i[11:8], 1'b0}));
        ImmU:     imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
        ImmJ:     imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                         instr_i[30:21], 1'b0}));
        ImmShamt: imm_o = XLEN'(Rv64 ? instr_i[25:20] : {1'b0, instr_i[24:20]});
        default:  imm_o = '0;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on entry and holds results in a 2-entry skid buffer.
module decode_stage import decode_pkg::*; #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1,
  parameter int unsigned PC_W     = 32
) (
  input logic           clk,
  input logic           rst,
  decode_stage_if.slave bus
);
  localparam int unsigned EntryW = entry_bits(XLEN, PC_W);

  logic [6:0]      dec_opcode, dec_funct7;
  logic [4:0]      dec_rs1, dec_rs2, dec_rd;
  logic [2:0]      dec_funct3;
  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_imm_type;
  logic            dec_illegal;

  logic [EntryW-1:0] new_entry;
  logic [EntryW-1:0] mem_q [2];
  logic [1:0]        count_q, count_d;
  logic              head_q, head_d, tail_q, tail_d;
  logic              accept, retire;

  decode_comb #(
    .XLEN     (XLEN),
    .ENABLE_M (ENABLE_M)
  ) u_decode_comb (
    .instr_i    (bus.instruction),
    .opcode_o   (dec_opcode),
    .rs1_o      (dec_rs1),
    .rs2_o      (dec_rs2),
    .rd_o       (dec_rd),
    .funct3_o   (dec_funct3),
    .funct7_o   (dec_funct7),
    .imm_o      (dec_imm),
    .imm_type_o (dec_imm_type),
    .illegal_o  (dec_illegal)
  );

  assign new_entry = {dec_opcode, dec_rs1, dec_rs2, dec_rd, dec_funct3, dec_funct7,
                      dec_imm, dec_imm_type, dec_illegal, bus.pcIn};

  // Ready depends only on the stored count, never on outReady.
  assign bus.inReady  = (count_q != 2'd2);
  assign bus.outValid = (count_q != 2'd0);
  assign accept       = bus.inValid && bus.inReady;
  assign retire       = bus.outValid && bus.outReady;

  assign {bus.opCode, bus.rs1, bus.rs2, bus.rd, bus.funct3, bus.funct7,
          bus.imm, bus.immType, bus.illegal, bus.pcOut} = mem_q[head_q];

  always_comb begin
    count_d = count_q + {1'b0, accept} - {1'b0, retire};
    head_d  = retire ? ~head_q : head_q;
    tail_d  = accept ? ~tail_q : tail_q;
    if (bus.flush) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      tail_q   <= 1'b0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (accept && !bus.flush) mem_q[tail_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomised bench: two decode_stage configs driven in lockstep against a queue-based model.
module tb_decode_stage;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(32), .PC_W(32)) if_a ();
  decode_stage_if #(.XLEN(64), .PC_W(32)) if_b ();

  decode_stage #(.XLEN(32), .ENABLE_M(1'b0), .PC_W(32)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  decode_stage #(.XLEN(64), .ENABLE_M(1'b1), .PC_W(32)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  typedef struct {
    logic [31:0] w;
    logic [31:0] pc;
  } item_t;

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [63:0] imm;
    logic [2:0]  it;
    logic        ill;
  } exp_t;

  item_t model_q[$];
  int    total = 0;
  int    bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint z(input logic [31:0] x);
    return longint'(x);
  endfunction

  // Reference decode from the ISA rules, using arithmetic for immediates.
  function automatic exp_t ref_decode(input logic [31:0] w, input int xlen, input bit m);
    exp_t   e;
    bit     u1, u2, ud;
    int     top;
    logic [2:0] f3;
    logic [6:0] f7;
    longint v;
    f3 = w[14:12];
    f7 = w[31:25];
    u1 = 0; u2 = 0; ud = 0;
    e.it  = ImmNone;
    e.ill = (w[1:0] != 2'b11);
    case (w[6:0])
      7'h37, 7'h17: begin e.it = ImmU; ud = 1; end
      7'h6f: begin e.it = ImmJ; ud = 1; end
      7'h67: begin e.it = ImmI; u1 = 1; ud = 1; end
      7'h03: begin
        e.it = ImmI; u1 = 1; ud = 1;
        if (f3 == 7 || (xlen == 32 && (f3 == 3 || f3 == 6))) e.ill = 1;
      end
      7'h23: begin
        e.it = ImmS; u1 = 1; u2 = 1;
        if (int'(f3) > (xlen == 64 ? 3 : 2)) e.ill = 1;
      end
      7'h63: begin
        e.it = ImmB; u1 = 1; u2 = 1;
        if (f3 == 2 || f3 == 3) e.ill = 1;
      end
      7'h13, 7'h1b: begin
        u1 = 1; ud = 1;
        if (w[6:0] == 7'h1b && xlen == 32) e.ill = 1;
        if (f3 == 1 || f3 == 5) begin
          e.it = ImmShamt;
          top = (xlen == 64) ? int'(w[31:26]) * 2 : int'(w[31:25]);
          if (!(top == 0 || (top == 32 && f3 == 5))) e.ill = 1;
        end else e.it = ImmI;
      end
      7'h33, 7'h3b: begin
        u1 = 1; u2 = 1; ud = 1;
        if (w[6:0] == 7'h3b && xlen == 32) e.ill = 1;
        if (!(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)) || (m && f7 == 1))) e.ill = 1;
      end
      7'h0f, 7'h73: ;
      default: e.ill = 1;
    endcase
    case (e.it)
      ImmI:     v = z(w[30:20]) - z(w[31]) * 2048;
      ImmS:     v = z(w[30:25]) * 32 + z(w[11:7]) - z(w[31]) * 2048;
      ImmB:     v = z(w[7]) * 2048 + z(w[30:25]) * 32 + z(w[11:8]) * 2 - z(w[31]) * 4096;
      ImmU:     v = z(w[30:12]) * 4096 - z(w[31]) * 64'sh8000_0000;
      ImmJ:     v = z(w[19:12]) * 4096 + z(w[20]) * 2048 + z(w[30:21]) * 2
                    - z(w[31]) * 64'sh10_0000;
      ImmShamt: v = (xlen == 64) ? z(w[25:20]) : z(w[24:20]);
      default:  v = 0;
    endcase
    if (e.ill) begin
      e.it = ImmNone; v = 0; u1 = 0; u2 = 0; ud = 0;
    end
    e.imm = (xlen == 64) ? 64'(v) : (64'(v) & 64'hFFFF_FFFF);
    e.rs1 = u1 ? w[19:15] : 5'd0;
    e.rs2 = u2 ? w[24:20] : 5'd0;
    e.rd  = ud ? w[11:7]  : 5'd0;
    return e;
  endfunction

  task automatic check_dut(input string tag, input int xlen, input bit m,
                           input logic ov, input logic ir, input logic [6:0] opc,
                           input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                           input logic [2:0] f3, input logic [6:0] f7, input logic [63:0] imm,
                           input logic [2:0] it, input logic ill, input logic [31:0] pc);
    exp_t e;
    check({tag, ".outValid"}, 64'(ov), 64'(model_q.size() != 0));
    check({tag, ".inReady"}, 64'(ir), 64'(model_q.size() < 2));
    if (model_q.size() != 0) begin
      e = ref_decode(model_q[0].w, xlen, m);
      check({tag, ".opCode"}, 64'(opc), 64'(model_q[0].w[6:0]));
      check({tag, ".funct3"}, 64'(f3), 64'(model_q[0].w[14:12]));
      check({tag, ".funct7"}, 64'(f7), 64'(model_q[0].w[31:25]));
      check({tag, ".rs1"}, 64'(r1), 64'(e.rs1));
      check({tag, ".rs2"}, 64'(r2), 64'(e.rs2));
      check({tag, ".rd"}, 64'(rd), 64'(e.rd));
      check({tag, ".imm"}, imm, e.imm);
      check({tag, ".immType"}, 64'(it), 64'(e.it));
      check({tag, ".illegal"}, 64'(ill), 64'(e.ill));
      check({tag, ".pcOut"}, 64'(pc), 64'(model_q[0].pc));
    end
  endtask

  task automatic check_both();
    check_dut("a", 32, 1'b0, if_a.outValid, if_a.inReady, if_a.opCode, if_a.rs1, if_a.rs2,
              if_a.rd, if_a.funct3, if_a.funct7, 64'(if_a.imm), if_a.immType, if_a.illegal,
              if_a.pcOut);
    check_dut("b", 64, 1'b1, if_b.outValid, if_b.inReady, if_b.opCode, if_b.rs1, if_b.rs2,
              if_b.rd, if_b.funct3, if_b.funct7, if_b.imm, if_b.immType, if_b.illegal,
              if_b.pcOut);
  endtask

  task automatic drive(input bit v, input logic [31:0] w, input bit ordy, input bit fl,
                       input logic [31:0] pc);
    if_a.inValid = v;  if_a.instruction = w;  if_a.outReady = ordy;
    if_a.flush   = fl; if_a.pcIn        = pc;
    if_b.inValid = v;  if_b.instruction = w;  if_b.outReady = ordy;
    if_b.flush   = fl; if_b.pcIn        = pc;
  endtask

  // One clock: present inputs, advance the model, then compare just after the edge.
  task automatic cycle(input bit v, input logic [31:0] w, input bit ordy, input bit fl);
    logic [31:0] pc;
    bit acc, ret;
    pc  = $urandom;
    drive(v, w, ordy, fl, pc);
    acc = v && (model_q.size() < 2);
    ret = (model_q.size() != 0) && ordy;
    if (fl) model_q.delete();
    else begin
      if (ret) void'(model_q.pop_front());
      if (acc) model_q.push_back('{w: w, pc: pc});
    end
    @(posedge clk);
    #1;
    check_both();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b1, 32'hFFF30293, 1'b0, 1'b0, 32'h1234);
    repeat (2) @(posedge clk);
    #1;
    model_q.delete();
    check("rst.a.outValid", 64'(if_a.outValid), 64'd0);
    check("rst.a.inReady", 64'(if_a.inReady), 64'd1);
    check("rst.a.rd", 64'(if_a.rd), 64'd0);
    check("rst.a.rs1", 64'(if_a.rs1), 64'd0);
    check("rst.a.imm", 64'(if_a.imm), 64'd0);
    check("rst.a.immType", 64'(if_a.immType), 64'(ImmNone));
    check("rst.a.illegal", 64'(if_a.illegal), 64'd0);
    check("rst.a.opCode", 64'(if_a.opCode), 64'd0);
    check("rst.a.pcOut", 64'(if_a.pcOut), 64'd0);
    check("rst.b.outValid", 64'(if_b.outValid), 64'd0);
    check("rst.b.inReady", 64'(if_b.inReady), 64'd1);
    check("rst.b.imm", if_b.imm, 64'd0);
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 14))
      0: w[6:0] = 7'h37;  1: w[6:0] = 7'h17;  2: w[6:0] = 7'h6f;  3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63;  5: w[6:0] = 7'h03;  6: w[6:0] = 7'h23;  7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33;  9: w[6:0] = 7'h1b; 10: w[6:0] = 7'h3b; 11: w[6:0] = 7'h0f;
      12: w[6:0] = 7'h73;
      default: ;
    endcase
    case ($urandom_range(0, 4))
      0: w[31:25] = 7'h00;
      1: w[31:25] = 7'h20;
      2: w[31:25] = 7'h01;
      3: w[31:25] = 7'h21;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    do_reset();

    // ADDI x5,x6,-1
    cycle(1, 32'hFFF30293, 1, 0);
    check("addi.valid", 64'(if_a.outValid), 64'd1);
    check("addi.rd", 64'(if_a.rd), 64'd5);
    check("addi.rs1", 64'(if_a.rs1), 64'd6);
    check("addi.imm", 64'(if_a.imm), 64'hFFFF_FFFF);
    check("addi.immType", 64'(if_a.immType), 64'(ImmI));

    // BEQ then SW back to back
    cycle(1, 32'hFE208EE3, 1, 0);
    check("beq.imm", 64'(if_a.imm), 64'hFFFF_FFFC);
    check("beq.immType", 64'(if_a.immType), 64'(ImmB));
    cycle(1, 32'h00322423, 1, 0);
    check("sw.valid", 64'(if_a.outValid), 64'd1);
    check("sw.imm", 64'(if_a.imm), 64'd8);
    check("sw.immType", 64'(if_a.immType), 64'(ImmS));
    cycle(0, 32'h0, 1, 0);

    // Backpressure: third offer must be refused, then drain in order
    cycle(1, 32'h00100093, 0, 0);
    cycle(1, 32'h00200113, 0, 0);
    check("bp.inReady", 64'(if_a.inReady), 64'd0);
    check("bp.head.rd", 64'(if_a.rd), 64'd1);
    cycle(1, 32'h00300193, 0, 0);
    check("bp.hold.rd", 64'(if_a.rd), 64'd1);
    repeat (3) cycle(0, 32'h0, 1, 0);

    // Flush with a full buffer and a live input
    cycle(1, 32'h00100093, 0, 0);
    cycle(1, 32'h00200113, 0, 0);
    cycle(1, 32'h00300193, 0, 1);
    check("flush.outValid", 64'(if_a.outValid), 64'd0);
    check("flush.inReady", 64'(if_a.inReady), 64'd1);
    cycle(0, 32'h0, 1, 0);
    check("flush.dropped", 64'(if_b.outValid), 64'd0);

    // MUL with and without M
    cycle(1, 32'h02208033, 1, 0);
    check("mul.a.illegal", 64'(if_a.illegal), 64'd1);
    check("mul.a.rd", 64'(if_a.rd), 64'd0);
    check("mul.b.illegal", 64'(if_b.illegal), 64'd0);
    check("mul.b.rs2", 64'(if_b.rs2), 64'd2);

    // SRAI x1,x1,33
    cycle(1, 32'h4210D093, 1, 0);
    check("srai.b.immType", 64'(if_b.immType), 64'(ImmShamt));
    check("srai.b.imm", if_b.imm, 64'd33);
    check("srai.b.illegal", 64'(if_b.illegal), 64'd0);
    check("srai.a.illegal", 64'(if_a.illegal), 64'd1);
    cycle(0, 32'h0, 1, 0);

    for (int i = 0; i < 800; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0);
      if (i == 400) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
